// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg                                                              |
// | Shared constants, width helpers and FSM encoding for the FFT power   |
// | reader.                                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fft_pkg;

  localparam int FFT_N = 32;
  localparam int NBIN  = FFT_N / 2 + 1;

  function automatic int pw(input int w);
    return 2 * w + 3;
  endfunction

  function automatic int aw(input int w, input int log2_avg);
    return pw(w) + log2_avg;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fft_bin_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_bin_acc                                                          |
// | Single-bin power accumulator: add, clear on completion, and a        |
// | shifted (averaged) view of accumulator plus the current sample.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_bin_acc
  import fft_pkg::*;
#(
  parameter  int PW       = pw(4),
  parameter  int LOG2_AVG = 2,
  localparam int AW       = PW + LOG2_AVG
) (
  input  logic          clk,
  input  logic          arstb,
  input  logic          add_i,
  input  logic          clr_i,
  input  logic [PW-1:0] din_i,
  output logic [PW-1:0] avg_o
);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] w_sum;

  assign w_sum = acc_q + AW'(din_i);
  // The final frame is folded in combinationally so the average is ready on the completing cycle.
  assign avg_o = PW'(w_sum >> LOG2_AVG);

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= w_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_power_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_power_reader                                                     |
// | Averages the per-bin power vector over 2^LOG2_AVG frames and streams |
// | the bins out on valid/ready. Optional peak search: FFT_PWR_PEAK_EN.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_power_reader
  import fft_pkg::*;
#(
  parameter  int W        = 4,
  parameter  int LOG2_AVG = 2,
  localparam int PW       = pw(W)
) (
  input  logic             clk,
  input  logic             arstb,
  input  logic             frame_valid,
  input  logic [NBIN*PW-1:0] pwr_bus,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [PW-1:0]    bin_data,
  output logic [4:0]       bin_idx,
  output logic             bin_last,
  output logic             busy,
  output logic [7:0]       drop_cnt
`ifdef FFT_PWR_PEAK_EN
  ,
  output logic [4:0]       peak_idx,
  output logic [PW-1:0]    peak_val,
  output logic             peak_valid
`endif
);

  logic                rstb_q;
  logic [LOG2_AVG-1:0] frm_cnt_q;
  logic                w_fv;
  logic                w_done;
  logic                w_hs;
  logic [4:0]          w_nxt_idx;
  logic [PW-1:0]       w_avg [NBIN];

  state_e        state_q;
  logic [PW-1:0] out_buf_q [NBIN];
  logic [PW-1:0] bin_data_q;
  logic [4:0]    bin_idx_q;
  logic          bin_last_q;
  logic          bin_valid_q;
  logic [7:0]    drop_cnt_q;

  assign w_fv      = frame_valid & rstb_q;
  assign w_done    = w_fv & (frm_cnt_q == '1);
  assign w_hs      = bin_valid_q & bin_ready;
  assign w_nxt_idx = bin_idx_q + 5'd1;

  for (genvar k = 0; k < NBIN; k++) begin : g_bin
    fft_bin_acc #(
      .PW       (PW),
      .LOG2_AVG (LOG2_AVG)
    ) u_acc (
      .clk   (clk),
      .arstb (arstb),
      .add_i (w_fv),
      .clr_i (w_done),
      .din_i (pwr_bus[k*PW +: PW]),
      .avg_o (w_avg[k])
    );
  end

  // Frame counter wraps to zero exactly on the completing frame.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      rstb_q    <= 1'b0;
      frm_cnt_q <= '0;
    end else begin
      rstb_q <= 1'b1;
      if (w_fv) begin
        frm_cnt_q <= frm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      state_q     <= ST_IDLE;
      bin_data_q  <= '0;
      bin_idx_q   <= '0;
      bin_last_q  <= 1'b0;
      bin_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
      for (int k = 0; k < NBIN; k++) begin
        out_buf_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_done) begin
            for (int k = 0; k < NBIN; k++) begin
              out_buf_q[k] <= w_avg[k];
            end
            bin_data_q  <= w_avg[0];
            bin_idx_q   <= '0;
            bin_last_q  <= 1'b0;
            bin_valid_q <= 1'b1;
            state_q     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // A completion here, even alongside the final handshake, is an overrun.
          if (w_done && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end
          if (w_hs) begin
            if (bin_last_q) begin
              bin_data_q  <= '0;
              bin_idx_q   <= '0;
              bin_last_q  <= 1'b0;
              bin_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              bin_data_q <= out_buf_q[w_nxt_idx];
              bin_idx_q  <= w_nxt_idx;
              bin_last_q <= (w_nxt_idx == 5'(NBIN - 1));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bin_valid = bin_valid_q;
  assign bin_data  = bin_data_q;
  assign bin_idx   = bin_idx_q;
  assign bin_last  = bin_last_q;
  assign busy      = (state_q == ST_STREAM);
  assign drop_cnt  = drop_cnt_q;

`ifdef FFT_PWR_PEAK_EN
  logic [PW-1:0] run_val_q;
  logic [4:0]    run_idx_q;
  logic [PW-1:0] peak_val_q;
  logic [4:0]    peak_idx_q;
  logic          peak_valid_q;
  logic          w_take;

  // Bin 1 seeds the search unconditionally; later bins replace it only when strictly larger.
  assign w_take = (bin_idx_q == 5'd1) || (bin_data_q > run_val_q);

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      run_val_q    <= '0;
      run_idx_q    <= '0;
      peak_val_q   <= '0;
      peak_idx_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (w_hs && bin_idx_q != 5'd0) begin
        if (bin_last_q) begin
          peak_valid_q <= 1'b1;
          peak_val_q   <= w_take ? bin_data_q : run_val_q;
          peak_idx_q   <= w_take ? bin_idx_q : run_idx_q;
        end else if (w_take) begin
          run_val_q <= bin_data_q;
          run_idx_q <= bin_idx_q;
        end
      end
    end
  end

  assign peak_val   = peak_val_q;
  assign peak_idx   = peak_idx_q;
  assign peak_valid = peak_valid_q;
`endif

endmodule
`default_nettype wire

// File: doc/fft_power_reader.md
Name: fft_power_reader

Overview:
- Consumer of the per-bin power vector produced by the FFT power stage: 17 bins, DC through Nyquist, each 2*W+3 bits.
- Averages the power vector over 2^LOG2_AVG frames, then streams the averaged bins out one per beat on a valid/ready interface for readout/capture logic.
- Double-buffered: accumulation of the next average continues while the previous average is being streamed.

Parameters:
- W, 4, FFT output sample width; power word width PW = 2*W+3.
- NBIN, 17, number of power bins per frame.
- LOG2_AVG, 2, log2 of the number of frames averaged; accumulator width AW = PW+LOG2_AVG.

Ports:
- clk  in  1  system clock, rising edge.
- arstb  in  1  asynchronous active-low reset.
- frame_valid  in  1  one-cycle strobe: pwr_bus holds a new power frame this cycle.
- pwr_bus  in  NBIN*PW  bin k at [k*PW +: PW]; unsigned, non-negative.
- bin_valid  out  1  stream beat valid.
- bin_ready  in  1  downstream accepts the beat.
- bin_data  out  PW  averaged power of the current bin.
- bin_idx  out  5  index of the current bin, 0..NBIN-1.
- bin_last  out  1  high on the beat with bin_idx = NBIN-1.
- busy  out  1  high while in STREAM.
- drop_cnt  out  8  count of averages lost to overrun; saturates at 255.

Behaviour:
- Reset: all outputs 0; accumulators, frame counter and out_buf cleared.
- Internal rstb flop: set 1 on the first clk after arstb release. While rstb=0, frame_valid is ignored.
- Accumulate:
  - On each frame_valid: acc[k] += pwr_bus bin k for every k; frm_cnt increments.
  - When frm_cnt = 2^LOG2_AVG-1 and frame_valid is high, the average completes that cycle.
  - Average = (acc[k] + current bin) >> LOG2_AVG, truncated, no rounding.
  - acc and frm_cnt are cleared in the same cycle as completion.
- FSM states: IDLE and STREAM.
  - IDLE: on average completion, load out_buf, set bin_idx=0, move to STREAM. bin_valid goes high the next cycle, giving a latency of 1 cycle from the completing frame_valid.
  - STREAM: bin_valid=1, bin_data=out_buf[bin_idx].
    - Handshake occurs when bin_valid & bin_ready. On handshake, bin_idx increments.
    - On handshake with bin_last=1: return to IDLE, bin_valid=0, bin_idx=0.
    - While bin_valid & !bin_ready: bin_data, bin_idx and bin_last are held stable.
- Overrun: an average completing while in STREAM is discarded; out_buf is untouched and drop_cnt increments (saturating). Accumulation of the following frames is not affected.
- Simultaneous events: a completion in the same cycle as the final handshake counts as overrun. The block returns to IDLE, and the next average is the first one streamed.
- Width: the accumulator cannot overflow because AW = PW+LOG2_AVG. An input power MSB of 1 is out of contract.
- arstb asserted mid-operation: immediate clear of all state and outputs. A partial average is discarded.

Optional Feature:
- Macro: FFT_PWR_PEAK_EN.
- Defined:
  - Extra outputs peak_idx (5 bits), peak_val (PW bits) and peak_valid (1 bit).
  - A running maximum is tracked over accepted beats with bin_idx 1..NBIN-1; DC is excluded.
  - Only a strictly greater value replaces the current maximum, so on ties the lowest index wins.
  - peak_valid pulses for 1 cycle, one cycle after the bin_last handshake. peak_idx and peak_val hold until the next pulse. All three reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fft_pkg holds:
  - Constants: FFT_N=32, NBIN=17, PW(W) = 2*W+3, AW.
  - FSM state encoding: ST_IDLE, ST_STREAM.
- One sub-module, fft_bin_acc: a single-bin accumulator with clear, add and shift-out, instantiated NBIN times by generate.
- FSM, out_buf and drop counter stay at top level.

Test Plan:
- Reset: hold arstb=0 for 3 cycles, then release. Required: all outputs 0, and a frame_valid on the first cycle after release is ignored (frm_cnt stays 0).
- Average: 4 frames with bin k = 4*k, bin_ready=1. Required:
  - 17 beats, bin_idx 0..16, bin_data = 4*k.
  - bin_last only on idx 16.
  - bin_valid rises 1 cycle after the 4th frame_valid.
- Truncation: bin 3 = 1, 1, 1, 2 over 4 frames. Required: bin_data = 1 at idx 3 (5>>2).
- Backpressure: bin_ready toggled 1/0 each cycle. Required: data stable while not ready, exactly 17 accepted beats in order, no duplicates.
- Overrun: bin_ready=0, 8 frames of bin k = 8. Required: drop_cnt=1, and streamed data is still the first average (8).
- Mid-stream reset: arstb pulsed at beat 5. Required: bin_valid=0 at once; after release, 4 fresh frames are needed before the next stream.
- FFT_PWR_PEAK_EN: bins 5 and 9 = 100, bin 0 = 200, others 10. Required: after the last beat, peak_idx=5, peak_val=100, and peak_valid pulses for 1 cycle.
